// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the sequenced board ALU.
// Holds the entry FSM state encoding, the MIPS funct opcodes the ALU
// understands, the bit positions inside the status flag vector and a
// helper that maps an FSM state onto the LED_STATE indicator pattern.
package alu_seq_pkg;

  // Entry / execute sequence states
  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } state_t;

  // Opcodes use the MIPS R-type funct field encoding
  localparam int          OP_W   = 6;
  localparam logic [5:0]  OP_ADD = 6'b100000;
  localparam logic [5:0]  OP_SUB = 6'b100010;
  localparam logic [5:0]  OP_AND = 6'b100100;
  localparam logic [5:0]  OP_OR  = 6'b100101;
  localparam logic [5:0]  OP_XOR = 6'b100110;
  localparam logic [5:0]  OP_NOR = 6'b100111;
  localparam logic [5:0]  OP_SRL = 6'b000010;
  localparam logic [5:0]  OP_SRA = 6'b000011;

  // Bit positions inside the 4-bit {err, ovf, carry, zero} flag vector
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_ERR   = 3;

  // One-hot {wait_op, wait_b, wait_a} indicator; dark while executing/showing
  function automatic logic [2:0] state_leds(input state_t s);
    logic [2:0] leds;
    case (s)
      S_WAIT_A:  leds = 3'b001;
      S_WAIT_B:  leds = 3'b010;
      S_WAIT_OP: leds = 3'b100;
      default:   leds = 3'b000;
    endcase
    return leds;
  endfunction

endpackage

// File: rtl/alu_seq_top_debounce.sv
// btn_debounce: pushbutton conditioner.
// The raw level is brought into the clock domain through two flops, then a
// change of level is accepted only after it has been seen for
// DEBOUNCE_CYCLES consecutive cycles. Each accepted 0->1 change produces a
// single registered one-cycle pulse; releases produce nothing.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic CLK100MHZ,
  input  logic RESET_N,
  input  logic btn_in,
  output logic btn_pulse
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_r;
  logic             level_r;
  logic [CNT_W-1:0] cnt_r;
  logic             pulse_r;

  // Synchronise the raw button, time a stable new level, pulse on acceptance of a press
  always_ff @(posedge CLK100MHZ) begin
    if (!RESET_N) begin
      sync_r  <= 2'b00;
      level_r <= 1'b0;
      cnt_r   <= '0;
      pulse_r <= 1'b0;
    end else begin
      sync_r  <= {sync_r[0], btn_in};
      pulse_r <= 1'b0;
      if (sync_r[1] == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        level_r <= sync_r[1];
        cnt_r   <= '0;
        pulse_r <= sync_r[1];
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign btn_pulse = pulse_r;

endmodule

// File: rtl/alu_seq_top.sv
// alu_seq_top: board-level sequenced ALU.
// Operands A, B and the opcode are entered from the switches one at a time
// with the debounced enter button (btnC); btnU clears back to operand A.
// The result and {err, ovf, carry, zero} flags are registered in a single
// execute cycle and held on the LEDs until the next execution or a clear.
// Optional feature macro ALU_ACCUM_EN: btnL in SHOW feeds the result back
// as operand A and jumps to operand B entry. Without it btnL is ignored.
module alu_seq_top
  import alu_seq_pkg::*;
#(
  parameter int OPERAND_SIZE    = 8,
  parameter int OP_CODE_SIZE    = 6,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                    CLK100MHZ,
  input  logic                    RESET_N,
  input  logic [OPERAND_SIZE-1:0] sw,
  input  logic                    btnC,
  input  logic                    btnU,
  input  logic                    btnL,
  output logic [OPERAND_SIZE-1:0] LED,
  output logic [2:0]              LED_STATE,
  output logic [3:0]              LED_FLAGS
);

  localparam int MSB = OPERAND_SIZE - 1;
  localparam logic [OP_CODE_SIZE-1:0] L_ADD = OP_CODE_SIZE'(OP_ADD);
  localparam logic [OP_CODE_SIZE-1:0] L_SUB = OP_CODE_SIZE'(OP_SUB);
  localparam logic [OP_CODE_SIZE-1:0] L_AND = OP_CODE_SIZE'(OP_AND);
  localparam logic [OP_CODE_SIZE-1:0] L_OR  = OP_CODE_SIZE'(OP_OR);
  localparam logic [OP_CODE_SIZE-1:0] L_XOR = OP_CODE_SIZE'(OP_XOR);
  localparam logic [OP_CODE_SIZE-1:0] L_NOR = OP_CODE_SIZE'(OP_NOR);
  localparam logic [OP_CODE_SIZE-1:0] L_SRL = OP_CODE_SIZE'(OP_SRL);
  localparam logic [OP_CODE_SIZE-1:0] L_SRA = OP_CODE_SIZE'(OP_SRA);
  localparam logic [OPERAND_SIZE-1:0] SH_LIMIT = OPERAND_SIZE'(OPERAND_SIZE);

  state_t                  state_r, next_state_s;
  logic [OPERAND_SIZE-1:0] a_r, b_r, result_r;
  logic [OP_CODE_SIZE-1:0] op_r;
  logic [3:0]              flags_r;
  logic [2:0]              led_state_r;
  logic                    enter_pulse_s, clear_pulse_s, chain_pulse_s;
  logic                    ld_a_s, ld_b_s, ld_op_s, ld_res_s, clr_s, chain_s;
  logic [OPERAND_SIZE-1:0] alu_res_s;
  logic [3:0]              alu_flags_s;
  logic [OPERAND_SIZE:0]   sum_s;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .CLK100MHZ(CLK100MHZ), .RESET_N(RESET_N), .btn_in(btnC), .btn_pulse(enter_pulse_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .CLK100MHZ(CLK100MHZ), .RESET_N(RESET_N), .btn_in(btnU), .btn_pulse(clear_pulse_s)
  );

`ifdef ALU_ACCUM_EN
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_chain (
    .CLK100MHZ(CLK100MHZ), .RESET_N(RESET_N), .btn_in(btnL), .btn_pulse(chain_pulse_s)
  );
`else
  assign chain_pulse_s = 1'b0;
`endif

  // State register plus the registered one-hot state indicator
  always_ff @(posedge CLK100MHZ) begin
    if (!RESET_N) begin
      state_r     <= S_WAIT_A;
      led_state_r <= 3'b001;
    end else begin
      state_r     <= next_state_s;
      led_state_r <= state_leds(next_state_s);
    end
  end

  // Next-state and register-load decisions; clear overrides everything else
  always_comb begin
    next_state_s = state_r;
    ld_a_s       = 1'b0;
    ld_b_s       = 1'b0;
    ld_op_s      = 1'b0;
    ld_res_s     = 1'b0;
    clr_s        = 1'b0;
    chain_s      = 1'b0;
    if (clear_pulse_s) begin
      clr_s        = 1'b1;
      next_state_s = S_WAIT_A;
    end else begin
      case (state_r)
        S_WAIT_A: begin
          if (enter_pulse_s) begin
            ld_a_s       = 1'b1;
            next_state_s = S_WAIT_B;
          end else begin
            next_state_s = S_WAIT_A;
          end
        end
        S_WAIT_B: begin
          if (enter_pulse_s) begin
            ld_b_s       = 1'b1;
            next_state_s = S_WAIT_OP;
          end else begin
            next_state_s = S_WAIT_B;
          end
        end
        S_WAIT_OP: begin
          if (enter_pulse_s) begin
            ld_op_s      = 1'b1;
            next_state_s = S_EXEC;
          end else begin
            next_state_s = S_WAIT_OP;
          end
        end
        S_EXEC: begin
          ld_res_s     = 1'b1;
          next_state_s = S_SHOW;
        end
        S_SHOW: begin
          if (enter_pulse_s) begin
            next_state_s = S_WAIT_A;
          end else if (chain_pulse_s) begin
            chain_s      = 1'b1;
            next_state_s = S_WAIT_B;
          end else begin
            next_state_s = S_SHOW;
          end
        end
        default: begin
          next_state_s = S_WAIT_A;
        end
      endcase
    end
  end

  // Operand, opcode and result/flag registers
  always_ff @(posedge CLK100MHZ) begin
    if (!RESET_N || clr_s) begin
      a_r      <= '0;
      b_r      <= '0;
      op_r     <= '0;
      result_r <= '0;
      flags_r  <= 4'b0000;
    end else begin
      if (ld_a_s) a_r <= sw;
      else if (chain_s) a_r <= result_r;
      if (ld_b_s) b_r <= sw;
      if (ld_op_s) op_r <= sw[OP_CODE_SIZE-1:0];
      if (ld_res_s) begin
        result_r <= alu_res_s;
        flags_r  <= alu_flags_s;
      end
    end
  end

  // ALU datapath on the captured operands; zero flag derived from the final result
  always_comb begin
    alu_res_s   = '0;
    alu_flags_s = 4'b0000;
    sum_s       = '0;
    case (op_r)
      L_ADD: begin
        sum_s                  = {1'b0, a_r} + {1'b0, b_r};
        alu_res_s              = sum_s[MSB:0];
        alu_flags_s[FLAG_CARRY] = sum_s[OPERAND_SIZE];
        alu_flags_s[FLAG_OVF]  = (a_r[MSB] == b_r[MSB]) && (alu_res_s[MSB] != a_r[MSB]);
      end
      L_SUB: begin
        sum_s                  = {1'b0, a_r} - {1'b0, b_r};
        alu_res_s              = sum_s[MSB:0];
        alu_flags_s[FLAG_CARRY] = (a_r < b_r);
        alu_flags_s[FLAG_OVF]  = (a_r[MSB] != b_r[MSB]) && (alu_res_s[MSB] != a_r[MSB]);
      end
      L_AND: alu_res_s = a_r & b_r;
      L_OR:  alu_res_s = a_r | b_r;
      L_XOR: alu_res_s = a_r ^ b_r;
      L_NOR: alu_res_s = ~(a_r | b_r);
      L_SRL: begin
        if (b_r >= SH_LIMIT) alu_res_s = '0;
        else alu_res_s = a_r >> b_r;
      end
      L_SRA: begin
        if (b_r >= SH_LIMIT) alu_res_s = {OPERAND_SIZE{a_r[MSB]}};
        else alu_res_s = $unsigned($signed(a_r) >>> b_r);
      end
      default: begin
        alu_res_s             = '0;
        alu_flags_s[FLAG_ERR] = 1'b1;
      end
    endcase
    alu_flags_s[FLAG_ZERO] = (alu_res_s == '0);
  end

  assign LED       = result_r;
  assign LED_FLAGS = flags_r;
  assign LED_STATE = led_state_r;

endmodule

// File: doc/alu_seq_top.md
# alu_seq_top

Parametrised, sequenced successor to the board-level ALU top. Operands and opcode are entered from the switches through a single debounced "enter" button and a one-hot slot FSM, replacing free-running level-sensitive buttons. The result and status flags are registered and held stable. It sits directly under the board constraints, driving LEDs from switches and pushbuttons.

## Interface
- OPERAND_SIZE, 8: operand/result width, ≥ 4
- OP_CODE_SIZE, 6: opcode width, taken from sw[OP_CODE_SIZE-1:0]; OPERAND_SIZE ≥ OP_CODE_SIZE
- DEBOUNCE_CYCLES, 1_000_000: stable cycles required before a button level is accepted (10 ms at 100 MHz)

- CLK100MHZ  in  1  sole clock; all logic on rising edge
- RESET_N  in  1  synchronous, active-low reset
- sw  in  OPERAND_SIZE  operand/opcode entry
- btnC  in  1  enter: capture sw into current slot, advance
- btnU  in  1  clear: abort entry, return to WAIT_A
- btnL  in  1  chain (only with ALU_ACCUM_EN)
- LED  out  OPERAND_SIZE  registered result
- LED_STATE  out  3  {wait_op, wait_b, wait_a}, one-hot while entering; 0 in EXEC/SHOW
- LED_FLAGS  out  4  {err, ovf, carry, zero}, registered with result

## Operation
- Buttons pass through btn_debounce: a level change is accepted after DEBOUNCE_CYCLES consecutive cycles of the new value. One-cycle pulse on each accepted 0→1 edge; nothing on release.
- FSM states: WAIT_A → WAIT_B → WAIT_OP → EXEC → SHOW → (enter) WAIT_A.
- Enter pulse in WAIT_A/WAIT_B/WAIT_OP: capture sw into A/B/op, advance one state.
- EXEC lasts exactly one cycle. It loads result_q and flags_q, then goes to SHOW.
- Enter in SHOW: go to WAIT_A. LED/LED_FLAGS hold the previous result until the next EXEC.
- Clear pulse in any state: go to WAIT_A and zero A, B, op, result_q and flags_q. Clear wins over simultaneous enter/chain.
- Ops, MIPS funct encoding:
  - ADD 100000: {carry,res}=A+B; ovf = signed overflow.
  - SUB 100010: res=A−B; carry = borrow (A<B unsigned); ovf = signed overflow.
  - AND 100100, OR 100101, XOR 100110, NOR 100111.
  - SRL 000010: A>>B. SRA 000011: A>>>B. Shift amount ≥ OPERAND_SIZE gives 0 (SRL) or all sign bits (SRA).
  - For logic and shift ops, carry=0 and ovf=0.
- Any other opcode: res=0, err=1, carry=ovf=0.
- zero = (res==0) for every op, including err.
- Reset: state WAIT_A. A, B, op, result_q, flags_q = 0. Debounce counters and stored levels = 0. LED=0, LED_FLAGS=0, LED_STATE=3'b001.

## Timing
- Enter pulse at cycle t (t = DEBOUNCE_CYCLES cycles after the raw button settles high): slot register and state update at edge ending t.
- Op captured at edge ending t → EXEC during t+1 → LED/LED_FLAGS valid and state SHOW from t+2.
- A button held longer than debounce yields exactly one pulse. Bounce shorter than DEBOUNCE_CYCLES yields none.
- RESET_N low mid-debounce or mid-sequence: all state is lost at the next edge. Buttons already held high at reset release are accepted only after a full stable period, then produce one pulse.
- All outputs are registered; no combinational path from sw/buttons to outputs.

## Configuration
- ALU_ACCUM_EN defined: a chain pulse (btnL) in SHOW copies result_q into A and goes to WAIT_B, so results can be chained. Chain in other states is ignored.
- Without it: btnL is not debounced, its debouncer is not instantiated, and the input is ignored.

## Structure
- Package alu_seq_pkg holds:
  - state enum
  - opcode localparams (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRL, OP_SRA)
  - flag bit indices
- Sub-module btn_debounce (params DEBOUNCE_CYCLES; ports CLK100MHZ, RESET_N, btn_in, btn_pulse) is instantiated once per button.
- The ALU datapath is an inline combinational function/always block inside alu_seq_top.

## Test plan
Bench runs with DEBOUNCE_CYCLES=4.
1. Reset, idle: LED=0, LED_FLAGS=0, LED_STATE=001. A 3-cycle btnC glitch → state stays 001.
2. Enter A=0x7F, B=0x01, op=0x20: two cycles after op capture, LED=0x80, flags={0,1,0,0}, LED_STATE=000.
3. A=0x05, B=0x07, op=0x22 → LED=0xFE, carry=1, ovf=0. A=0x80, B=0x03, op=0x03 → LED=0xF0. With B=0x09 → LED=0xFF.
4. op=0x3F → LED=0x00, err=1, zero=1. Then btnC → WAIT_A with LED still 0x00.
5. btnU and btnC pulse in the same cycle while in WAIT_OP → WAIT_A, A=B=0, no capture. RESET_N low mid-sequence → reset values next cycle.
6. ALU_ACCUM_EN: result 0x10, btnL, B=0x01, op=ADD → LED=0x11. Without the macro, btnL has no effect.
